// File: rtl/flag_branch_ctrl.sv
// Sequencer between decoder, ALU and fetch: launches ALU ops, owns the S/V/Z
// flags, evaluates conditional branches and issues PC redirects to fetch.
module flag_branch_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_class,
  input  logic [2:0]        cond,
  input  logic [ADDR_W-1:0] target,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic              alu_s,
  input  logic              alu_v,
  input  logic              alu_z,
  output logic [2:0]        flags,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic              alu_err,
  output logic              busy
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ALU_WAIT, EVAL, REDIRECT} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          class_reg, class_next;
  logic [2:0]          cond_reg, cond_next;
  logic [ADDR_W-1:0]   target_reg, target_next;
  logic [WAIT_W-1:0]   wait_reg, wait_next;
  logic [2:0]          flags_reg, flags_next;
  logic                redirect_valid_reg, redirect_valid_next;
  logic [ADDR_W-1:0]   redirect_pc_reg, redirect_pc_next;
  logic                alu_start_reg, alu_start_next;
  logic [CNT_W-1:0]    taken_cnt_reg, taken_cnt_next;
  logic                alu_err_reg, alu_err_next;
  logic                instr_ready_reg, busy_reg;

  // Flags are packed {S,V,Z}.
  function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
    logic s, v, z;
    s = f[2];
    v = f[1];
    z = f[0];
    case (c)
      3'b000:  cond_true = z;
      3'b001:  cond_true = !z;
      3'b010:  cond_true = s;
      3'b011:  cond_true = !s;
      3'b100:  cond_true = v;
      3'b101:  cond_true = !v;
      3'b110:  cond_true = (s == v);
      default: cond_true = (s != v);
    endcase
  endfunction

  always_comb begin
    state_next          = state_reg;
    class_next          = class_reg;
    cond_next           = cond_reg;
    target_next         = target_reg;
    wait_next           = wait_reg;
    flags_next          = flags_reg;
    redirect_valid_next = redirect_valid_reg;
    redirect_pc_next    = redirect_pc_reg;
    alu_start_next      = 1'b0;
    taken_cnt_next      = taken_cnt_reg;
    alu_err_next        = alu_err_reg;

    if (flush) begin
      // Abort wins over any completion or handshake in the same cycle.
      state_next          = IDLE;
      redirect_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            class_next  = instr_class;
            cond_next   = cond;
            target_next = target;
            case (instr_class)
              2'b00, 2'b01: begin
                state_next     = ALU_WAIT;
                alu_start_next = 1'b1;
                wait_next      = WAIT_W'(1);
              end
              2'b10: state_next = EVAL;
              default: begin
                state_next          = REDIRECT;
                redirect_pc_next    = target;
                redirect_valid_next = 1'b1;
              end
            endcase
          end
        end
        ALU_WAIT: begin
          if (alu_done) begin
            if (class_reg == 2'b01) flags_next = {alu_s, alu_v, alu_z};
            state_next = IDLE;
          end else if (wait_reg == WAIT_W'(TIMEOUT)) begin
            alu_err_next = 1'b1;
            state_next   = IDLE;
          end else begin
            wait_next = wait_reg + WAIT_W'(1);
          end
        end
        EVAL: begin
          // Uses the stored flags, which already reflect a just-finished ALU op.
          if (cond_true(cond_reg, flags_reg)) begin
            redirect_pc_next    = target_reg;
            redirect_valid_next = 1'b1;
            state_next          = REDIRECT;
          end else begin
            state_next = IDLE;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid_next = 1'b0;
            if (taken_cnt_reg != {CNT_W{1'b1}}) taken_cnt_next = taken_cnt_reg + CNT_W'(1);
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= IDLE;
      class_reg          <= 2'b00;
      cond_reg           <= 3'b000;
      target_reg         <= '0;
      wait_reg           <= '0;
      flags_reg          <= 3'b000;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      alu_start_reg      <= 1'b0;
      taken_cnt_reg      <= '0;
      alu_err_reg        <= 1'b0;
      instr_ready_reg    <= 1'b1;
      busy_reg           <= 1'b0;
    end else begin
      state_reg          <= state_next;
      class_reg          <= class_next;
      cond_reg           <= cond_next;
      target_reg         <= target_next;
      wait_reg           <= wait_next;
      flags_reg          <= flags_next;
      redirect_valid_reg <= redirect_valid_next;
      redirect_pc_reg    <= redirect_pc_next;
      alu_start_reg      <= alu_start_next;
      taken_cnt_reg      <= taken_cnt_next;
      alu_err_reg        <= alu_err_next;
      instr_ready_reg    <= (state_next == IDLE);
      busy_reg           <= (state_next != IDLE);
    end
  end

  assign instr_ready    = instr_ready_reg;
  assign busy           = busy_reg;
  assign alu_start      = alu_start_reg;
  assign flags          = flags_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign taken_cnt      = taken_cnt_reg;
  assign alu_err        = alu_err_reg;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Directed bench for flag_branch_ctrl; a second instance with CNT_W=2 checks saturation.
module tb_flag_branch_ctrl;
  logic        clk = 1'b0;
  logic        reset, flush, instr_valid, alu_done, alu_s, alu_v, alu_z, redirect_ready;
  logic [1:0]  instr_class;
  logic [2:0]  cond;
  logic [15:0] target;

  logic        instr_ready, alu_start, redirect_valid, alu_err, busy;
  logic [2:0]  flags;
  logic [15:0] redirect_pc;
  logic [7:0]  taken_cnt;

  logic        d2_instr_ready, d2_alu_start, d2_redirect_valid, d2_alu_err, d2_busy;
  logic [2:0]  d2_flags;
  logic [15:0] d2_redirect_pc;
  logic [1:0]  d2_taken_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  flag_branch_ctrl #(.ADDR_W(16), .CNT_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .flush(flush), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_class(instr_class), .cond(cond), .target(target),
    .alu_start(alu_start), .alu_done(alu_done), .alu_s(alu_s), .alu_v(alu_v), .alu_z(alu_z),
    .flags(flags), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .taken_cnt(taken_cnt), .alu_err(alu_err), .busy(busy)
  );

  flag_branch_ctrl #(.ADDR_W(16), .CNT_W(2), .TIMEOUT(15)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .instr_valid(instr_valid),
    .instr_ready(d2_instr_ready), .instr_class(instr_class), .cond(cond), .target(target),
    .alu_start(d2_alu_start), .alu_done(alu_done), .alu_s(alu_s), .alu_v(alu_v), .alu_z(alu_z),
    .flags(d2_flags), .redirect_valid(d2_redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(d2_redirect_pc), .taken_cnt(d2_taken_cnt), .alu_err(d2_alu_err), .busy(d2_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction and lets it be accepted on the next edge.
  task automatic issue(input logic [1:0] c, input logic [2:0] cd, input logic [15:0] t);
    instr_valid = 1'b1; instr_class = c; cond = cd; target = t;
    tick();
    instr_valid = 1'b0;
    $display("issued class=%b cond=%b target=%h", c, cd, t);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({flags, redirect_valid, redirect_pc, alu_start, taken_cnt, alu_err, busy, instr_ready} !==
        {3'b000, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL reset_state flags=%b rv=%b pc=%h start=%b cnt=%0d err=%b busy=%b rdy=%b required 000 0 0000 0 0 0 0 1",
               flags, redirect_valid, redirect_pc, alu_start, taken_cnt, alu_err, busy, instr_ready);
      fails++;
    end
    $display("test_reset complete");
  endtask

  task automatic test_alu_set_flags();
    alu_s = 1'b1; alu_v = 1'b0; alu_z = 1'b0;
    issue(2'b01, 3'b000, 16'h0);
    checks++;
    if ({alu_start, busy, instr_ready} !== 3'b110) begin
      $display("FAIL alu_start_first start/busy/rdy=%b required 110", {alu_start, busy, instr_ready});
      fails++;
    end
    tick();
    checks++;
    if (alu_start !== 1'b0) begin
      $display("FAIL alu_start_one_cycle start=%b required 0", alu_start); fails++;
    end
    tick(); tick();
    alu_done = 1'b1;
    checks++;
    if (flags !== 3'b000) begin
      $display("FAIL flags_before_done flags=%b required 000", flags); fails++;
    end
    tick();
    alu_done = 1'b0;
    checks++;
    if ({flags, instr_ready, busy} !== 5'b10010) begin
      $display("FAIL alu_set_flags flags=%b rdy=%b busy=%b required 100 1 0", flags, instr_ready, busy);
      fails++;
    end
    $display("test_alu_set_flags complete");
  endtask

  task automatic test_back_to_back();
    alu_s = 1'b0; alu_v = 1'b0; alu_z = 1'b1; alu_done = 1'b1;
    issue(2'b00, 3'b000, 16'h0);
    tick();
    alu_done = 1'b0;
    checks++;
    if ({flags, instr_ready} !== 4'b1001) begin
      $display("FAIL class00_flags flags=%b rdy=%b required 100 1", flags, instr_ready); fails++;
    end
    issue(2'b10, 3'b010, 16'h0040);
    checks++;
    if ({redirect_valid, busy} !== 2'b01) begin
      $display("FAIL eval_no_redirect rv/busy=%b required 01", {redirect_valid, busy}); fails++;
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({redirect_valid, redirect_pc} !== {1'b1, 16'h0040}) begin
        $display("FAIL redirect_hold cycle %0d rv=%b pc=%h required 1 0040", i, redirect_valid, redirect_pc);
        fails++;
      end
      tick();
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checks++;
    if ({redirect_valid, taken_cnt, instr_ready} !== {1'b0, 8'd1, 1'b1}) begin
      $display("FAIL redirect_handshake rv=%b cnt=%0d rdy=%b required 0 1 1", redirect_valid, taken_cnt, instr_ready);
      fails++;
    end
    $display("test_back_to_back complete");
  endtask

  task automatic test_not_taken();
    alu_s = 1'b0; alu_v = 1'b0; alu_z = 1'b1; alu_done = 1'b1;
    issue(2'b01, 3'b000, 16'h0);
    tick();
    alu_done = 1'b0;
    checks++;
    if (flags !== 3'b001) begin
      $display("FAIL flags_z flags=%b required 001", flags); fails++;
    end
    issue(2'b10, 3'b001, 16'h0bad);
    checks++;
    if (instr_ready !== 1'b0) begin
      $display("FAIL eval_not_ready rdy=%b required 0", instr_ready); fails++;
    end
    tick();
    checks++;
    if ({instr_ready, redirect_valid, taken_cnt} !== {1'b1, 1'b0, 8'd1}) begin
      $display("FAIL not_taken rdy=%b rv=%b cnt=%0d required 1 0 1", instr_ready, redirect_valid, taken_cnt);
      fails++;
    end
    // GE with S=1,V=1 and the flags written just before the branch.
    alu_s = 1'b1; alu_v = 1'b1; alu_z = 1'b0; alu_done = 1'b1;
    issue(2'b01, 3'b000, 16'h0);
    tick();
    alu_done = 1'b0;
    issue(2'b10, 3'b110, 16'h1234);
    tick();
    checks++;
    if ({flags, redirect_valid, redirect_pc} !== {3'b110, 1'b1, 16'h1234}) begin
      $display("FAIL ge_taken flags=%b rv=%b pc=%h required 110 1 1234", flags, redirect_valid, redirect_pc);
      fails++;
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checks++;
    if (taken_cnt !== 8'd2) begin
      $display("FAIL ge_count cnt=%0d required 2", taken_cnt); fails++;
    end
    $display("test_not_taken complete");
  endtask

  task automatic test_saturation();
    logic [1:0] exp2 [5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      issue(2'b11, 3'b000, 16'h0100 + 16'(k));
      checks++;
      if ({redirect_valid, redirect_pc} !== {1'b1, 16'h0100 + 16'(k)}) begin
        $display("FAIL uncond_redirect %0d rv=%b pc=%h required 1 %h", k, redirect_valid, redirect_pc, 16'h0100 + 16'(k));
        fails++;
      end
      redirect_ready = 1'b1;
      tick();
      redirect_ready = 1'b0;
      checks++;
      if ({d2_taken_cnt, taken_cnt} !== {exp2[k], 8'(k + 1)}) begin
        $display("FAIL sat_count %0d cnt2=%0d cnt8=%0d required %0d %0d", k, d2_taken_cnt, taken_cnt, exp2[k], k + 1);
        fails++;
      end
    end
    $display("test_saturation complete");
  endtask

  task automatic test_timeout();
    alu_s = 1'b1; alu_v = 1'b1; alu_z = 1'b1;
    issue(2'b01, 3'b000, 16'h0);
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if ({busy, alu_err} !== 2'b10) begin
      $display("FAIL timeout_cycle15 busy/err=%b required 10", {busy, alu_err}); fails++;
    end
    tick();
    checks++;
    if ({busy, alu_err, flags} !== {1'b0, 1'b1, 3'b000}) begin
      $display("FAIL timeout_abort busy=%b err=%b flags=%b required 0 1 000", busy, alu_err, flags); fails++;
    end
    do_reset();
    alu_s = 1'b1; alu_v = 1'b0; alu_z = 1'b1;
    issue(2'b01, 3'b000, 16'h0);
    for (int i = 0; i < 14; i++) tick();
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    checks++;
    if ({busy, alu_err, flags} !== {1'b0, 1'b0, 3'b101}) begin
      $display("FAIL done_in_cycle15 busy=%b err=%b flags=%b required 0 0 101", busy, alu_err, flags); fails++;
    end
    $display("test_timeout complete");
  endtask

  task automatic test_flush();
    issue(2'b11, 3'b000, 16'h0077);
    flush = 1'b1; redirect_ready = 1'b1;
    tick();
    flush = 1'b0; redirect_ready = 1'b0;
    checks++;
    if ({busy, redirect_valid, taken_cnt} !== {1'b0, 1'b0, 8'd0}) begin
      $display("FAIL flush_redirect busy=%b rv=%b cnt=%0d required 0 0 0", busy, redirect_valid, taken_cnt); fails++;
    end
    alu_s = 1'b0; alu_v = 1'b1; alu_z = 1'b0;
    issue(2'b01, 3'b000, 16'h0);
    flush = 1'b1; alu_done = 1'b1;
    tick();
    flush = 1'b0; alu_done = 1'b0;
    checks++;
    if ({busy, flags, alu_start} !== {1'b0, 3'b101, 1'b0}) begin
      $display("FAIL flush_alu busy=%b flags=%b start=%b required 0 101 0", busy, flags, alu_start); fails++;
    end
    instr_valid = 1'b1; instr_class = 2'b11; target = 16'h0055; flush = 1'b1;
    tick();
    instr_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({busy, redirect_valid, instr_ready} !== 3'b001) begin
      $display("FAIL flush_idle busy/rv/rdy=%b required 001", {busy, redirect_valid, instr_ready}); fails++;
    end
    $display("test_flush complete");
  endtask

  task automatic test_reset_mid();
    issue(2'b11, 3'b000, 16'h0abc);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    issue(2'b01, 3'b000, 16'h0);
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if ({alu_err, taken_cnt} !== {1'b1, 8'd1}) begin
      $display("FAIL pre_reset_state err=%b cnt=%0d required 1 1", alu_err, taken_cnt); fails++;
    end
    issue(2'b01, 3'b000, 16'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({flags, redirect_valid, redirect_pc, alu_start, taken_cnt, alu_err, busy} !==
        {3'b000, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0}) begin
      $display("FAIL reset_mid flags=%b rv=%b pc=%h start=%b cnt=%0d err=%b busy=%b required all zero",
               flags, redirect_valid, redirect_pc, alu_start, taken_cnt, alu_err, busy);
      fails++;
    end
    $display("test_reset_mid complete");
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; instr_valid = 1'b0; instr_class = 2'b00; cond = 3'b000;
    target = 16'h0; alu_done = 1'b0; alu_s = 1'b0; alu_v = 1'b0; alu_z = 1'b0; redirect_ready = 1'b0;
    test_reset();
    test_alu_set_flags();
    test_back_to_back();
    test_not_taken();
    test_saturation();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
